mul16_seq_ctrl: RTL and testbench

- Sequencer that computes an unsigned 2*CORE_W x 2*CORE_W product by time-multiplexing one shared CORE_W x CORE_W Dadda multiplier core.
- The core consists of the partial-product generator, the compressor tree and the final adder, and is purely combinational.
- The block splits each operand into halves and drives four half-products through the core on consecutive cycles. It accumulates them with shifts and returns the full product over a valid/ready handshake.
- It sits between the requesting datapath and the multiplier core.

---
 rtl/mul16_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_mul16_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl.sv
// Sequencer for a 2*CORE_W x 2*CORE_W unsigned product built from four passes
// through one shared CORE_W x CORE_W combinational multiplier core.
module mul16_seq_ctrl #(
  parameter int CORE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*CORE_W-1:0]   a,
  input  logic [2*CORE_W-1:0]   b,
  output logic [CORE_W-1:0]     mul_a,
  output logic [CORE_W-1:0]     mul_b,
  input  logic [2*CORE_W-1:0]   mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*CORE_W-1:0]   result,
  output logic                  busy,
  output logic [1:0]            step
);

  localparam int OW = 2 * CORE_W;
  localparam int RW = 4 * CORE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      step_r;
  logic [OW-1:0]   a_r;
  logic [OW-1:0]   b_r;
  logic [RW-1:0]   acc_r;
  logic [RW-1:0]   pp_s;
  logic [RW-1:0]   acc_s;
  logic            accept_s;
  logic            zero_s;

  assign accept_s = in_valid && (state_r == ST_IDLE);
  assign zero_s   = (a == {OW{1'b0}}) || (b == {OW{1'b0}});

  // Next-state decode plus core operand select and shifted half-product.
  always_comb begin
    state_s = state_r;
    mul_a   = {CORE_W{1'b0}};
    mul_b   = {CORE_W{1'b0}};
    pp_s    = {RW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = zero_s ? ST_DONE : ST_MUL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        // Cross terms share the CORE_W shift; the hi*hi term lands at 2*CORE_W.
        case (step_r)
          2'd0: begin
            mul_a = a_r[CORE_W-1:0];
            mul_b = b_r[CORE_W-1:0];
            pp_s  = {{OW{1'b0}}, mul_p};
          end
          2'd1: begin
            mul_a = a_r[CORE_W-1:0];
            mul_b = b_r[OW-1:CORE_W];
            pp_s  = {{CORE_W{1'b0}}, mul_p, {CORE_W{1'b0}}};
          end
          2'd2: begin
            mul_a = a_r[OW-1:CORE_W];
            mul_b = b_r[CORE_W-1:0];
            pp_s  = {{CORE_W{1'b0}}, mul_p, {CORE_W{1'b0}}};
          end
          2'd3: begin
            mul_a = a_r[OW-1:CORE_W];
            mul_b = b_r[OW-1:CORE_W];
            pp_s  = {mul_p, {OW{1'b0}}};
          end
          default: begin
            mul_a = {CORE_W{1'b0}};
            mul_b = {CORE_W{1'b0}};
            pp_s  = {RW{1'b0}};
          end
        endcase
        if (step_r == 2'd3) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign acc_s = acc_r + pp_s;

  // State, operand capture, step counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      step_r  <= 2'd0;
      a_r     <= {OW{1'b0}};
      b_r     <= {OW{1'b0}};
      acc_r   <= {RW{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r    <= a;
            b_r    <= b;
            acc_r  <= {RW{1'b0}};
            step_r <= 2'd0;
          end
        end
        ST_MUL: begin
          acc_r  <= acc_s;
          step_r <= step_r + 2'd1;
        end
        default: begin
          step_r <= step_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign result    = acc_r;
  assign step      = (state_r == ST_MUL) ? step_r : 2'd0;

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench for mul16_seq_ctrl: the shared core is modelled as a plain
// multiply and every result is checked against a*b computed by the bench.
module tb_mul16_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic [1:0]  step;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mul16_seq_ctrl #(.CORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .step(step)
  );

  assign mul_p = 16'(mul_a) * 16'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Presents a request at a negedge where in_ready is high; returns at cycle 1.
  task automatic issue(input logic [15:0] aa, input logic [15:0] bb);
    in_valid = 1'b1; a = aa; b = bb;
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
  endtask

  // Waits (bounded) for out_valid; lat is the cycle index it was seen in.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, step, mul_a, mul_b, result} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h0, 8'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b ov=%b busy=%b step=%0d ma=%h mb=%h res=%h, want rdy=1 all else 0",
               in_ready, out_valid, busy, step, mul_a, mul_b, result);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ema [4] = '{8'h34, 8'h34, 8'h12, 8'h12};
    logic [7:0] emb [4] = '{8'h78, 8'h56, 8'h78, 8'h56};
    issue(16'h1234, 16'h5678);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({mul_a, mul_b, in_ready, busy, step} !== {ema[k], emb[k], 1'b0, 1'b1, 2'(k)}) begin
        n_err++;
        $display("FAIL directed_cycle%0d: got ma=%h mb=%h rdy=%b busy=%b step=%0d, want ma=%h mb=%h rdy=0 busy=1 step=%0d",
                 k + 1, mul_a, mul_b, in_ready, busy, step, ema[k], emb[k], k);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h06260060}) begin
      n_err++;
      $display("FAIL directed_done: got ov=%b rdy=%b res=%h, want ov=1 rdy=0 res=06260060",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL directed_idle: got rdy=%b ov=%b, want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] aa, bb;
    int lat;
    for (int i = 0; i < 18; i++) begin
      aa = 16'($urandom); bb = 16'($urandom);
      if (i == 0) begin aa = 16'hFFFF; bb = 16'hFFFF; end
      if ($urandom_range(0, 5) == 0) aa = 16'h0;
      if ($urandom_range(0, 5) == 0) bb = 16'h0;
      issue(aa, bb);
      wait_out(lat);
      n_cmp++;
      if (result !== 32'(aa) * 32'(bb) || lat != ((aa == 16'h0 || bb == 16'h0) ? 1 : 5)) begin
        n_err++;
        $display("FAIL random_%0d: %h*%h got res=%h lat=%0d, want res=%h lat=%0d", i, aa, bb, result, lat,
                 32'(aa) * 32'(bb), (aa == 16'h0 || bb == 16'h0) ? 1 : 5);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero();
    int lat;
    n_cmp++;
    if ({mul_a, mul_b} !== 16'h0) begin
      n_err++;
      $display("FAIL zero_pre_core: got ma=%h mb=%h, want 00 00", mul_a, mul_b);
    end
    issue(16'h0000, 16'hABCD);
    wait_out(lat);
    n_cmp++;
    if ({lat == 1, result, mul_a, mul_b, busy} !== {1'b1, 32'h0, 8'h0, 8'h0, 1'b1}) begin
      n_err++;
      $display("FAIL zero_skip: got lat=%0d res=%h ma=%h mb=%h busy=%b, want lat=1 res=0 ma=0 mb=0 busy=1",
               lat, result, mul_a, mul_b, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({in_ready, mul_a, mul_b} !== {1'b1, 8'h0, 8'h0}) begin
      n_err++;
      $display("FAIL zero_after: got rdy=%b ma=%h mb=%h, want rdy=1 0 0", in_ready, mul_a, mul_b);
    end
  endtask

  task automatic test_stall();
    int lat;
    int bad = 0;
    out_ready = 1'b0;
    issue(16'h00FF, 16'h0100);
    wait_out(lat);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h0000FF00}) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0 || lat != 5) begin
      n_err++;
      $display("FAIL stall_hold: got %0d bad cycles lat=%0d last ov=%b rdy=%b res=%h, want 0 bad lat=5 res=0000ff00",
               bad, lat, out_valid, in_ready, result);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'h0000FF00}) begin
      n_err++;
      $display("FAIL stall_release: got rdy=%b ov=%b busy=%b res=%h, want rdy=1 ov=0 busy=0 res=0000ff00",
               in_ready, out_valid, busy, result);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(16'h1234, 16'h5678);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, mul_a, mul_b, busy} !== {1'b0, 8'h0, 8'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_abort: got ov=%b ma=%h mb=%h busy=%b, want all 0", out_valid, mul_a, mul_b, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'd2, 16'd3);
    wait_out(lat);
    n_cmp++;
    if (result !== 32'd6 || lat != 5) begin
      n_err++;
      $display("FAIL reset_mid_after: got res=%h lat=%0d, want res=6 lat=5", result, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    int acc_t [3];
    logic [31:0] got [$];
    for (int i = 0; i < 3; i++) begin
      av[i] = 16'($urandom) | 16'h0001;
      bv[i] = 16'($urandom) | 16'h0100;
    end
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int k = 0;
          a = av[i]; b = bv[i]; in_valid = 1'b1;
          while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
          end
          acc_t[i] = cyc;
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (out_valid && out_ready) got.push_back(result);
        end
      end
    join
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got.size() <= i || got[i] !== 32'(av[i]) * 32'(bv[i])) begin
        n_err++;
        $display("FAIL b2b_result_%0d: got %h (n=%0d), want %h", i,
                 (got.size() > i) ? got[i] : 32'hx, got.size(), 32'(av[i]) * 32'(bv[i]));
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (acc_t[i] - acc_t[i-1] != 6) begin
        n_err++;
        $display("FAIL b2b_spacing_%0d: got %0d cycles, want 6", i, acc_t[i] - acc_t[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
